// File: rtl/bus_arbiter2_if.sv
// Handshake bundle between the fetch/LSU requesters, the memory port and bus_arbiter2.
// master = arbiter side, slave = requester/memory side.
interface bus_arbiter2_if;
  logic req0;
  logic req1;
  logic mem_ready;
  logic gnt0;
  logic gnt1;
  logic done0;
  logic done1;
  logic mem_valid;
  logic sel;
  logic busy;

  modport master (
    input  req0, req1, mem_ready,
    output gnt0, gnt1, done0, done1, mem_valid, sel, busy
  );

  modport slave (
    output req0, req1, mem_ready,
    input  gnt0, gnt1, done0, done1, mem_valid, sel, busy
  );
endinterface

// File: rtl/bus_arbiter2.sv
// Two-requester arbiter (0 = fetch, 1 = data) for the shared memory port.
// Define BUS_ARBITER2_ROUND_ROBIN_EN for round-robin ties; otherwise data wins every tie.
module bus_arbiter2 (
  input  logic            clock,
  input  logic            reset,
  bus_arbiter2_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state;
  logic   last;      // most recently granted requester
  logic   gnt0_r;
  logic   gnt1_r;
  logic   sel_r;
  logic   active_r;  // drives both mem_valid and busy
  logic   pick1;

`ifdef BUS_ARBITER2_ROUND_ROBIN_EN
  // On a tie, grant whoever was not served last.
  assign pick1 = bus.req1 && (!bus.req0 || !last);
`else
  assign pick1 = bus.req1;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      gnt0_r   <= 1'b0;
      gnt1_r   <= 1'b0;
      sel_r    <= 1'b0;
      active_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state    <= pick1 ? GRANT1 : GRANT0;
            last     <= pick1;
            gnt0_r   <= !pick1;
            gnt1_r   <= pick1;
            sel_r    <= pick1;
            active_r <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          // No abort path: only mem_ready ends a grant, regardless of req.
          if (bus.mem_ready) begin
            state    <= IDLE;
            gnt0_r   <= 1'b0;
            gnt1_r   <= 1'b0;
            sel_r    <= 1'b0;
            active_r <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          gnt0_r   <= 1'b0;
          gnt1_r   <= 1'b0;
          sel_r    <= 1'b0;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_r;
  assign bus.gnt1      = gnt1_r;
  assign bus.sel       = sel_r;
  assign bus.mem_valid = active_r;
  assign bus.busy      = active_r;
  assign bus.done0     = (state == GRANT0) && bus.mem_ready;
  assign bus.done1     = (state == GRANT1) && bus.mem_ready;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed self-checking bench for bus_arbiter2; expectations follow
// BUS_ARBITER2_ROUND_ROBIN_EN when it is defined for the build.
module tb_bus_arbiter2;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  bus_arbiter2_if bus ();

  bus_arbiter2 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output vector order: {gnt0, gnt1, done0, done1, mem_valid, sel, busy}
  localparam logic [6:0] IDLE_V = 7'b0000000;

  function automatic logic [6:0] g0(input logic d);
    return {1'b1, 1'b0, d, 1'b0, 1'b1, 1'b0, 1'b1};
  endfunction

  function automatic logic [6:0] g1(input logic d);
    return {1'b0, 1'b1, 1'b0, d, 1'b1, 1'b1, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] expected);
    logic [6:0] observed;
    #1;
    observed = {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_valid, bus.sel, bus.busy};
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    logic [6:0] exp_v;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.req0      = 1'b1;
    bus.req1      = 1'b1;
    bus.mem_ready = 1'b1;

    // Reset held two cycles with both requests high: everything quiet.
    tick();
    check("reset_c1", IDLE_V);
    tick();
    check("reset_c2", IDLE_V);
    bus.mem_ready = 1'b0;
    reset         = 1'b0;

    // First tie after reset.
    tick();
`ifdef BUS_ARBITER2_ROUND_ROBIN_EN
    check("first_tie_grant", g0(1'b0));
`else
    check("first_tie_grant", g1(1'b0));
`endif
    bus.req0      = 1'b0;
    bus.req1      = 1'b0;
    bus.mem_ready = 1'b1;
`ifdef BUS_ARBITER2_ROUND_ROBIN_EN
    check("first_tie_done", g0(1'b1));
`else
    check("first_tie_done", g1(1'b1));
`endif
    tick();
    check("idle_ignores_ready", IDLE_V);

    // Single fetch, zero wait.
    bus.mem_ready = 1'b0;
    bus.req0      = 1'b1;
    check("fetch_c0_idle", IDLE_V);
    tick();
    bus.mem_ready = 1'b1;
    bus.req0      = 1'b0;
    check("fetch_c1_done", g0(1'b1));
    tick();
    bus.mem_ready = 1'b0;
    check("fetch_c2_idle", IDLE_V);

    // Data access with three wait states.
    bus.req1 = 1'b1;
    tick();
    check("data_wait1", g1(1'b0));
    tick();
    check("data_wait2", g1(1'b0));
    tick();
    check("data_wait3", g1(1'b0));
    tick();
    bus.mem_ready = 1'b1;
    bus.req1      = 1'b0;
    check("data_c4_done", g1(1'b1));
    tick();
    bus.mem_ready = 1'b0;
    check("data_idle", IDLE_V);

    // Continuous contention with zero-wait memory; last grant was requester 1.
    bus.req0      = 1'b1;
    bus.req1      = 1'b1;
    bus.mem_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 8) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      if (k % 2 == 0) begin
        exp_v = IDLE_V;
      end else begin
`ifdef BUS_ARBITER2_ROUND_ROBIN_EN
        exp_v = (k == 1 || k == 5) ? g0(1'b1) : g1(1'b1);
`else
        exp_v = g1(1'b1);
`endif
      end
      check($sformatf("contention_c%0d", k), exp_v);
    end
    bus.mem_ready = 1'b0;
    tick();
    check("contention_end_idle", IDLE_V);

    // Request withdrawn mid-grant: transfer still completes.
    bus.req0 = 1'b1;
    tick();
    bus.req0 = 1'b0;
    check("withdraw_grant", g0(1'b0));
    tick();
    check("withdraw_hold1", g0(1'b0));
    tick();
    check("withdraw_hold2", g0(1'b0));
    bus.mem_ready = 1'b1;
    check("withdraw_done", g0(1'b1));
    tick();
    bus.mem_ready = 1'b0;
    check("withdraw_idle", IDLE_V);

    // Reset during GRANT1 aborts silently and restores last = 1.
    bus.req1 = 1'b1;
    tick();
    check("abort_grant1", g1(1'b0));
    reset = 1'b1;
    tick();
    check("abort_reset_idle", IDLE_V);
    reset    = 1'b0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    tick();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
`ifdef BUS_ARBITER2_ROUND_ROBIN_EN
    check("post_reset_tie", g0(1'b0));
`else
    check("post_reset_tie", g1(1'b0));
`endif
    bus.mem_ready = 1'b1;
`ifdef BUS_ARBITER2_ROUND_ROBIN_EN
    check("post_reset_done", g0(1'b1));
`else
    check("post_reset_done", g1(1'b1));
`endif
    tick();
    bus.mem_ready = 1'b0;
    check("final_idle", IDLE_V);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
